// File: rtl/prf_read_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prf_read_scheduler                                                       |
// | Round-robin first-fit sharing of PRF read ports among ALU/branch/LSU,    |
// | with writeback bypass and a one-entry output stage per functional unit.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module prf_read_scheduler #(
  parameter int NUM_PORTS = 4,
  parameter int PREG_W    = 7,
  parameter int PAYLOAD_W = 64
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_flush,
  input  logic [2:0]                    i_req_valid,
  input  logic [3*PREG_W-1:0]           i_req_ps1,
  input  logic [3*PREG_W-1:0]           i_req_ps2,
  input  logic [3*PAYLOAD_W-1:0]        i_req_payload,
  output logic [2:0]                    o_req_ready,
  output logic [NUM_PORTS-1:0]          o_rd_en,
  output logic [NUM_PORTS*PREG_W-1:0]   o_rd_addr,
  input  logic [NUM_PORTS*32-1:0]       i_rd_data,
  input  logic                          i_wb_valid,
  input  logic [PREG_W-1:0]             i_wb_preg,
  input  logic [31:0]                   i_wb_data,
  output logic [2:0]                    o_out_valid,
  output logic [3*32-1:0]               o_out_ps1_data,
  output logic [3*32-1:0]               o_out_ps2_data,
  output logic [3*PAYLOAD_W-1:0]        o_out_payload,
  input  logic [2:0]                    i_fu_ready
);

  logic [1:0]           r_rr_ptr;
  logic [2:0]           r_out_valid;
  logic [3*32-1:0]      r_out_ps1;
  logic [3*32-1:0]      r_out_ps2;
  logic [3*PAYLOAD_W-1:0] r_out_payload;

  logic [PREG_W-1:0]    w_ps1  [3];
  logic [PREG_W-1:0]    w_ps2  [3];
  logic [1:0]           w_need [3];
  logic [2:0]           w_nz1;
  logic [2:0]           w_nz2;
  logic [2:0]           w_elig;
  logic [31:0]          w_prf1 [3];
  logic [31:0]          w_prf2 [3];
  logic [31:0]          w_op1  [3];
  logic [31:0]          w_op2  [3];
  logic [2:0]           w_grant;
  logic                 w_any;
  logic [1:0]           w_first;
  logic [3:0]           w_used;
  logic [2:0]           w_sum;
  logic [1:0]           w_idx;

  for (genvar gi = 0; gi < 3; gi++) begin : g_req
    assign w_ps1[gi]  = i_req_ps1[gi*PREG_W +: PREG_W];
    assign w_ps2[gi]  = i_req_ps2[gi*PREG_W +: PREG_W];
    assign w_nz1[gi]  = (w_ps1[gi] != '0);
    assign w_nz2[gi]  = (w_ps2[gi] != '0);
    assign w_need[gi] = {1'b0, w_nz1[gi]} + {1'b0, w_nz2[gi]};
    assign w_elig[gi] = i_req_valid[gi] & (~r_out_valid[gi] | i_fu_ready[gi])
                        & ~i_flush & ~i_reset;
    // A matching writeback overrides the PRF value read this cycle.
    assign w_op1[gi]  = !w_nz1[gi] ? 32'd0 :
                        (i_wb_valid && (i_wb_preg == w_ps1[gi])) ? i_wb_data : w_prf1[gi];
    assign w_op2[gi]  = !w_nz2[gi] ? 32'd0 :
                        (i_wb_valid && (i_wb_preg == w_ps2[gi])) ? i_wb_data : w_prf2[gi];
  end

  always_comb begin
    w_grant   = '0;
    w_any     = 1'b0;
    w_first   = '0;
    w_used    = '0;
    w_sum     = '0;
    w_idx     = '0;
    o_rd_en   = '0;
    o_rd_addr = '0;
    for (int i = 0; i < 3; i++) begin
      w_prf1[i] = '0;
      w_prf2[i] = '0;
    end
    // Visit from the round-robin pointer; ports are handed out in visit order.
    for (int k = 0; k < 3; k++) begin
      w_sum = {1'b0, r_rr_ptr} + 3'(k);
      w_idx = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
      if (w_elig[w_idx] && ((w_used + {2'b00, w_need[w_idx]}) <= 4'(NUM_PORTS))) begin
        w_grant[w_idx] = 1'b1;
        if (!w_any) w_first = w_idx;
        w_any = 1'b1;
        if (w_nz1[w_idx]) begin
          for (int j = 0; j < NUM_PORTS; j++) begin
            if (j == int'(w_used)) begin
              o_rd_en[j]                   = 1'b1;
              o_rd_addr[j*PREG_W +: PREG_W] = w_ps1[w_idx];
              w_prf1[w_idx]                = i_rd_data[j*32 +: 32];
            end
          end
          w_used = w_used + 4'd1;
        end
        if (w_nz2[w_idx]) begin
          for (int j = 0; j < NUM_PORTS; j++) begin
            if (j == int'(w_used)) begin
              o_rd_en[j]                   = 1'b1;
              o_rd_addr[j*PREG_W +: PREG_W] = w_ps2[w_idx];
              w_prf2[w_idx]                = i_rd_data[j*32 +: 32];
            end
          end
          w_used = w_used + 4'd1;
        end
      end
    end
  end

  assign o_req_ready = w_grant;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr_ptr <= 2'd0;
    end else if (w_any) begin
      r_rr_ptr <= (w_first == 2'd2) ? 2'd0 : w_first + 2'd1;
    end
  end

  for (genvar go = 0; go < 3; go++) begin : g_out
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_out_valid[go]                       <= 1'b0;
        r_out_ps1[go*32 +: 32]                <= '0;
        r_out_ps2[go*32 +: 32]                <= '0;
        r_out_payload[go*PAYLOAD_W +: PAYLOAD_W] <= '0;
      end else if (i_flush) begin
        r_out_valid[go] <= 1'b0;
      end else if (w_grant[go]) begin
        r_out_valid[go]                       <= 1'b1;
        r_out_ps1[go*32 +: 32]                <= w_op1[go];
        r_out_ps2[go*32 +: 32]                <= w_op2[go];
        r_out_payload[go*PAYLOAD_W +: PAYLOAD_W] <= i_req_payload[go*PAYLOAD_W +: PAYLOAD_W];
      end else if (i_fu_ready[go]) begin
        r_out_valid[go] <= 1'b0;
      end
    end
  end

  assign o_out_valid    = r_out_valid;
  assign o_out_ps1_data = r_out_ps1;
  assign o_out_ps2_data = r_out_ps2;
  assign o_out_payload  = r_out_payload;

endmodule
`default_nettype wire

// File: tb/tb_prf_read_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_prf_read_scheduler                                                    |
// | Directed and randomized checks against a behavioural scheduler model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_prf_read_scheduler;
  localparam int NP = 4;
  localparam int PW = 7;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            reset, flush;
  logic [2:0]      req_valid, req_ready, out_valid, fu_ready;
  logic [PW-1:0]   ps1 [3];
  logic [PW-1:0]   ps2 [3];
  logic [DW-1:0]   pay [3];
  logic [3*PW-1:0] req_ps1, req_ps2;
  logic [3*DW-1:0] req_payload, out_payload;
  logic [NP-1:0]   rd_en;
  logic [NP*PW-1:0] rd_addr;
  logic [NP*32-1:0] rd_data;
  logic            wb_valid;
  logic [PW-1:0]   wb_preg;
  logic [31:0]     wb_data;
  logic [3*32-1:0] out_ps1, out_ps2;
  logic [31:0]     mem [128];

  int n_err = 0;
  int n_checks = 0;

  // behavioural model state
  int          exp_rr;
  bit          exp_v [3];
  logic [31:0] exp_d1 [3];
  logic [31:0] exp_d2 [3];
  logic [DW-1:0] exp_p [3];
  // per-cycle predictions
  logic [2:0]    pg;
  logic [NP-1:0] pen;
  logic [NP*PW-1:0] paddr;
  int            pfirst;
  bit            pany;
  logic [31:0]   po1 [3];
  logic [31:0]   po2 [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_pack
    assign req_ps1[g*PW +: PW]     = ps1[g];
    assign req_ps2[g*PW +: PW]     = ps2[g];
    assign req_payload[g*DW +: DW] = pay[g];
  end
  for (genvar g = 0; g < NP; g++) begin : g_prf
    assign rd_data[g*32 +: 32] = mem[rd_addr[g*PW +: PW]];
  end

  prf_read_scheduler #(.NUM_PORTS(NP), .PREG_W(PW), .PAYLOAD_W(DW)) dut (
    .i_clk(clk), .i_reset(reset), .i_flush(flush),
    .i_req_valid(req_valid), .i_req_ps1(req_ps1), .i_req_ps2(req_ps2),
    .i_req_payload(req_payload), .o_req_ready(req_ready),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .i_wb_valid(wb_valid), .i_wb_preg(wb_preg), .i_wb_data(wb_data),
    .o_out_valid(out_valid), .o_out_ps1_data(out_ps1), .o_out_ps2_data(out_ps2),
    .o_out_payload(out_payload), .i_fu_ready(fu_ready)
  );

  function automatic logic [31:0] opnd(input logic [PW-1:0] ps);
    if (ps == 0) return 32'd0;
    if (wb_valid && wb_preg == ps) return wb_data;
    return mem[ps];
  endfunction

  task automatic predict();
    int used;
    int i;
    int need;
    bit elig;
    used = 0; pg = '0; pen = '0; paddr = '0; pany = 0; pfirst = 0;
    for (int k = 0; k < 3; k++) begin
      i = (exp_rr + k) % 3;
      need = (ps1[i] != 0 ? 1 : 0) + (ps2[i] != 0 ? 1 : 0);
      elig = req_valid[i] && (!exp_v[i] || fu_ready[i]) && !flush && !reset;
      po1[i] = opnd(ps1[i]);
      po2[i] = opnd(ps2[i]);
      if (elig && used + need <= NP) begin
        pg[i] = 1'b1;
        if (!pany) pfirst = i;
        pany = 1;
        if (ps1[i] != 0) begin pen[used] = 1'b1; paddr[used*PW +: PW] = ps1[i]; used++; end
        if (ps2[i] != 0) begin pen[used] = 1'b1; paddr[used*PW +: PW] = ps2[i]; used++; end
      end
    end
  endtask

  // Move one clock edge forward, applying the model's view of that edge.
  task automatic advance();
    predict();
    @(posedge clk);
    if (reset) begin
      exp_rr = 0;
      for (int i = 0; i < 3; i++) begin exp_v[i] = 0; exp_d1[i] = 0; exp_d2[i] = 0; exp_p[i] = 0; end
    end else if (flush) begin
      for (int i = 0; i < 3; i++) exp_v[i] = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (pg[i]) begin
          exp_v[i] = 1; exp_d1[i] = po1[i]; exp_d2[i] = po2[i]; exp_p[i] = pay[i];
        end else if (fu_ready[i]) exp_v[i] = 0;
      end
      if (pany) exp_rr = (pfirst + 1) % 3;
    end
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b, input logic [DW-1:0] p);
    ps1[i] = PW'(a); ps2[i] = PW'(b); pay[i] = p;
  endtask

  task automatic test_reset();
    reset = 1; flush = 0; req_valid = 3'b111; fu_ready = 3'b111; wb_valid = 0;
    wb_preg = 0; wb_data = 0;
    for (int i = 0; i < 3; i++) set_req(i, i + 1, i + 2, 64'hA5A5 + 64'(i));
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
      n_checks++; if (rd_en !== '0) begin n_err++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
      advance();
    end
    reset = 0; req_valid = 3'b000;
    @(negedge clk);
    n_checks++; if (out_valid !== 3'b000) begin n_err++; $display("FAIL reset_out_valid got=%b exp=000", out_valid); end
    n_checks++; if (out_ps1 !== '0 || out_ps2 !== '0 || out_payload !== '0) begin
      n_err++; $display("FAIL reset_out_data got=%h/%h/%h exp=0", out_ps1, out_ps2, out_payload); end
    advance();
  endtask

  task automatic test_contention();
    logic [2:0]       er [3];
    logic [NP*PW-1:0] ea [3];
    er[0] = 3'b011; ea[0] = {7'd4, 7'd3, 7'd2, 7'd1};
    er[1] = 3'b110; ea[1] = {7'd6, 7'd5, 7'd4, 7'd3};
    er[2] = 3'b101; ea[2] = {7'd2, 7'd1, 7'd6, 7'd5};
    fu_ready = 3'b111; req_valid = 3'b111;
    set_req(0, 1, 2, 64'h100); set_req(1, 3, 4, 64'h200); set_req(2, 5, 6, 64'h300);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (req_ready !== er[c]) begin n_err++; $display("FAIL contention_ready[%0d] got=%b exp=%b", c, req_ready, er[c]); end
      n_checks++; if (rd_addr !== ea[c]) begin n_err++; $display("FAIL contention_addr[%0d] got=%h exp=%h", c, rd_addr, ea[c]); end
      advance();
    end
    n_checks++; if (out_ps2[0 +: 32] !== mem[2]) begin n_err++; $display("FAIL contention_alu_ps2 got=%h exp=%h", out_ps2[0 +: 32], mem[2]); end
    req_valid = 3'b000;
  endtask

  task automatic test_x0_packing();
    req_valid = 3'b111;
    set_req(0, 0, 5, 64'h11); set_req(1, 9, 0, 64'h22); set_req(2, 3, 4, 64'h33);
    @(negedge clk);
    n_checks++; if (req_ready !== 3'b111) begin n_err++; $display("FAIL x0_ready got=%b exp=111", req_ready); end
    n_checks++; if (rd_addr !== {7'd4, 7'd3, 7'd9, 7'd5} || rd_en !== 4'hF) begin
      n_err++; $display("FAIL x0_addr got=%h en=%b exp=%h en=1111", rd_addr, rd_en, {7'd4, 7'd3, 7'd9, 7'd5}); end
    advance();
    n_checks++; if (out_ps1[0 +: 32] !== 32'd0) begin n_err++; $display("FAIL x0_alu_ps1 got=%h exp=0", out_ps1[0 +: 32]); end
    n_checks++; if (out_ps2[0 +: 32] !== mem[5]) begin n_err++; $display("FAIL x0_alu_ps2 got=%h exp=%h", out_ps2[0 +: 32], mem[5]); end
    req_valid = 3'b000;
  endtask

  task automatic test_bypass();
    mem[12] = 32'h0;
    req_valid = 3'b001; set_req(0, 12, 0, 64'h44);
    wb_valid = 1; wb_preg = 7'd12; wb_data = 32'hDEADBEEF;
    @(negedge clk);
    advance();
    n_checks++; if (out_ps1[0 +: 32] !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_ps1 got=%h exp=deadbeef", out_ps1[0 +: 32]); end
    wb_valid = 0; req_valid = 3'b000;
  endtask

  task automatic test_backpressure();
    fu_ready = 3'b111; req_valid = 3'b100; set_req(2, 20, 21, 64'hBEEF_0000);
    @(negedge clk);
    n_checks++; if (req_ready[2] !== 1'b1) begin n_err++; $display("FAIL bp_first_ready got=%b exp=1", req_ready[2]); end
    advance();
    fu_ready = 3'b011; set_req(2, 22, 23, 64'hBEEF_1111);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (req_ready[2] !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready[%0d] got=%b exp=0", c, req_ready[2]); end
      advance();
      n_checks++; if (out_valid[2] !== 1'b1 || out_payload[2*DW +: DW] !== 64'hBEEF_0000 || out_ps1[64 +: 32] !== mem[20]) begin
        n_err++; $display("FAIL bp_hold[%0d] got v=%b p=%h d=%h exp v=1 p=beef0000 d=%h", c, out_valid[2], out_payload[2*DW +: DW], out_ps1[64 +: 32], mem[20]); end
    end
    fu_ready = 3'b111;
    @(negedge clk);
    n_checks++; if (req_ready[2] !== 1'b1) begin n_err++; $display("FAIL bp_regrant got=%b exp=1", req_ready[2]); end
    advance();
    n_checks++; if (out_payload[2*DW +: DW] !== 64'hBEEF_1111 || out_ps1[64 +: 32] !== mem[22]) begin
      n_err++; $display("FAIL bp_newdata got p=%h d=%h exp p=beef1111 d=%h", out_payload[2*DW +: DW], out_ps1[64 +: 32], mem[22]); end
    req_valid = 3'b000;
  endtask

  task automatic test_flush();
    fu_ready = 3'b111; req_valid = 3'b111;
    set_req(0, 30, 0, 64'hF0); set_req(1, 31, 0, 64'hF1); set_req(2, 32, 0, 64'hF2);
    @(negedge clk); advance();
    n_checks++; if (out_valid !== 3'b111) begin n_err++; $display("FAIL flush_fill got=%b exp=111", out_valid); end
    flush = 1;
    @(negedge clk);
    n_checks++; if (req_ready !== 3'b000 || rd_en !== '0) begin n_err++; $display("FAIL flush_nogrant got=%b en=%b exp=000 en=0", req_ready, rd_en); end
    advance();
    n_checks++; if (out_valid !== 3'b000) begin n_err++; $display("FAIL flush_clear got=%b exp=000", out_valid); end
    n_checks++; if (out_payload[0 +: DW] !== 64'hF0) begin n_err++; $display("FAIL flush_data_held got=%h exp=f0", out_payload[0 +: DW]); end
    flush = 0;
    @(negedge clk);
    n_checks++; if (req_ready !== 3'b111) begin n_err++; $display("FAIL flush_resume got=%b exp=111", req_ready); end
    advance();
    n_checks++; if (out_valid !== 3'b111) begin n_err++; $display("FAIL flush_refill got=%b exp=111", out_valid); end
  endtask

  task automatic test_reset_mid();
    fu_ready = 3'b000; reset = 1;
    @(negedge clk);
    n_checks++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL rstmid_ready got=%b exp=000", req_ready); end
    advance();
    n_checks++; if (out_valid !== 3'b000 || out_payload !== '0) begin n_err++; $display("FAIL rstmid_drop got v=%b p=%h exp 0", out_valid, out_payload); end
    reset = 0; fu_ready = 3'b111; req_valid = 3'b000;
  endtask

  task automatic test_random();
    int err0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 3; i++)
        set_req(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 127),
                   ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 127),
                {$urandom, $urandom});
      req_valid = 3'($urandom);
      fu_ready  = 3'($urandom);
      flush     = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 49) == 0);
      wb_valid  = $urandom_range(0, 1);
      wb_preg   = ($urandom_range(0, 1) == 1) ? ps1[$urandom_range(0, 2)] : PW'($urandom);
      wb_data   = $urandom;
      @(negedge clk);
      predict();
      err0 = n_err;
      n_checks++; if (req_ready !== pg) begin n_err++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, pg); end
      n_checks++; if (rd_en !== pen) begin n_err++; $display("FAIL rand_rd_en c=%0d got=%b exp=%b", c, rd_en, pen); end
      n_checks++; if (rd_addr !== paddr) begin n_err++; $display("FAIL rand_rd_addr c=%0d got=%h exp=%h", c, rd_addr, paddr); end
      advance();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (out_valid[i] !== exp_v[i] || out_ps1[i*32 +: 32] !== exp_d1[i] ||
            out_ps2[i*32 +: 32] !== exp_d2[i] || out_payload[i*DW +: DW] !== exp_p[i]) begin
          n_err++;
          $display("FAIL rand_out c=%0d fu=%0d got v=%b %h %h %h exp v=%b %h %h %h", c, i,
                   out_valid[i], out_ps1[i*32 +: 32], out_ps2[i*32 +: 32], out_payload[i*DW +: DW],
                   exp_v[i], exp_d1[i], exp_d2[i], exp_p[i]);
        end
      end
      if (n_err - err0 > 0 && n_err > 20) break;
    end
    reset = 0; flush = 0; req_valid = 3'b000; wb_valid = 0;
  endtask

  initial begin
    exp_rr = 0;
    for (int i = 0; i < 3; i++) begin exp_v[i] = 0; exp_d1[i] = 0; exp_d2[i] = 0; exp_p[i] = 0; end
    for (int j = 0; j < 128; j++) mem[j] = $urandom;
    test_reset();
    test_contention();
    test_x0_packing();
    test_bypass();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prf_read_scheduler.md
# prf_read_scheduler

Shares a reduced set of physical-register-file read ports among the three issue paths (ALU, branch, LSU) of the out-of-order core. It sits between the reservation stations and the functional units. Each cycle it arbitrates issue requests round-robin, packs each winner's source reads onto free PRF ports, and forwards same-cycle writeback data. It then registers operands plus payload into a one-entry output stage per functional unit with a valid/ready handshake.

## Interface
Parameters:
- NUM_PORTS, 4: PRF read ports available (legal 2..6).
- PREG_W, 7: physical register index width.
- PAYLOAD_W, 64: opaque issue payload carried alongside operands.

Ports (index i: 0=ALU, 1=branch, 2=LSU):
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  branch-mispredict flush
- req_valid  in  3  issue request per requester
- req_ps1, req_ps2  in  3×PREG_W  source physical registers; 0 means x0, no port needed
- req_payload  in  3×PAYLOAD_W  passed through untouched
- req_ready  out  3  grant; request consumed this cycle when req_valid & req_ready
- rd_en  out  NUM_PORTS  PRF read enable per port
- rd_addr  out  NUM_PORTS×PREG_W  PRF read address per port
- rd_data  in  NUM_PORTS×32  PRF read data, combinational from rd_addr
- wb_valid  in  1  writeback this cycle
- wb_preg  in  PREG_W  writeback destination
- wb_data  in  32  writeback value
- out_valid  out  3  operands valid to FU i
- out_ps1_data, out_ps2_data  out  3×32  operands
- out_payload  out  3×PAYLOAD_W  payload
- fu_ready  in  3  FU i accepts the output entry this cycle

## Operation
- need[i] = (req_ps1[i]!=0) + (req_ps2[i]!=0), range 0..2.
- slot_free[i] = !out_valid[i] | fu_ready[i].
- eligible[i] = req_valid[i] & slot_free[i] & !flush & !reset.
- Arbitration:
  - Visit requesters in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - Grant an eligible requester if used+need[i] ≤ NUM_PORTS, then add need[i] to used.
  - A requester that does not fit is skipped; later ones are still considered (first-fit).
- Port packing: granted requesters take consecutive ports from port 0 in visit order, ps1 before ps2; x0 sources take no port. Unused ports: rd_en=0, rd_addr=0.
- Operand select, per granted source:
  - x0 gives 0.
  - Else if wb_valid and wb_preg equals the source, gives wb_data (bypass; wb_preg=0 never bypasses).
  - Else gives rd_data of the assigned port.
- Output stage i:
  - On grant: load out_valid=1, operands, payload.
  - Else if fu_ready[i]: clear out_valid.
  - Else: hold all fields stable.
- rr_ptr: if any grant, becomes (first granted requester in visit order)+1 mod 3; else unchanged.
- flush: clears all out_valid at the edge and suppresses all grants that cycle. rr_ptr and data fields are unchanged.

## Timing
- Reset values: out_valid=000, out_ps1_data/out_ps2_data/out_payload=0, rr_ptr=0.
- Combinational outputs (req_ready, rd_en, rd_addr) are 0 while reset is high.
- req_ready, rd_en and rd_addr are combinational in the request cycle T.
- Operands and payload appear with out_valid one cycle later (T+1). Latency is 1 cycle; throughput is 1 per FU per cycle when fu_ready is held high.
- Back-to-back: a full slot with fu_ready=1 can be refilled in the same cycle.
- Full slot with fu_ready=0: req_ready[i]=0 and the stage holds.
- Simultaneous flush and fu_ready: flush wins; slot is empty next cycle.
- Reset mid-operation: all in-flight entries are dropped at the edge and the request is not granted.
- No combinational path from req_* to out_*.

## Test plan
- Reset: hold reset 2 cycles with all req_valid=1. Required: req_ready=000, rd_en=0, out_valid=000 and out data 0 after release.
- Full contention, NUM_PORTS=4: all three request with nonzero ps1/ps2, rr_ptr=0. Required: cycle 1 grants ALU (ports 0,1) and branch (ports 2,3), LSU stalls, rr_ptr becomes 1. Cycle 2 grants branch and LSU, rr_ptr becomes 2. No requester waits more than 2 cycles.
- x0 packing: ALU ps1=0, ps2=5; branch ps1=9, ps2=0; LSU ps1=3, ps2=4. Required: all three granted with rd_addr={5,9,3,4}, and ALU out_ps1_data=0 at T+1.
- Bypass: ALU ps1=12 with wb_valid=1, wb_preg=12, wb_data=0xDEADBEEF, PRF returning 0x0. Required: out_ps1_data[ALU]=0xDEADBEEF at T+1.
- Backpressure: LSU out_valid=1 with fu_ready[2]=0 for 3 cycles while LSU keeps requesting. Required: req_ready[2]=0 and the output is held unchanged. Raising fu_ready[2] gives a same-cycle regrant and new data next cycle.
- Flush: flush=1 while out_valid=111 and all requesting. Required: out_valid=000 next cycle, no grants that cycle, and normal grants resume the cycle after.
